branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk_i and rst_ni.
REQ-002 Parameter XLEN, default 32: operand, PC and immediate width; legal value 32 or 64.
REQ-003 Parameter STAGES, default 1: pipeline depth; legal value 1 or 2.
REQ-004 Parameter CNTW, default 16: width of each performance counter.
REQ-005 The ports SHALL be, in this order:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  branch request present
- ready_o  out  1  request accepted this cycle when high with valid_i
- funct3_i  in  3  branch type (RV32I B-format funct3)
- rs1_i, rs2_i  in  XLEN each  compare operands
- pc_i  in  XLEN  branch PC
- imm_i  in  XLEN  sign-extended offset
- pred_taken_i  in  1  front-end prediction
- flush_i  in  1  kill all in-flight entries
- valid_o  out  1  result present
- ready_i  in  1  downstream accepts result
- taken_o  out  1  resolved direction
- next_pc_o  out  XLEN  resolved next PC
- mispredict_o  out  1  taken_o differs from the prediction
- illegal_o  out  1  unsupported funct3
- BrEq_o, BrLt_o  out  1 each  raw compare flags
- br_cnt_o, mp_cnt_o  out  CNTW each  retired-branch and mispredict counters

Function
REQ-006 The comparison SHALL be computed as follows:
- eq = (rs1 == rs2)
- lt = signed rs1 < rs2
- ltu = unsigned rs1 < rs2
- BrLt_o SHALL be lt for signed funct3 (100, 101) and ltu otherwise.
REQ-007 funct3 decode for taken SHALL be:
- 000 -> eq; 001 -> !eq
- 100 -> lt; 101 -> !lt
- 110 -> ltu; 111 -> !ltu
- 010 or 011 -> taken=0, illegal_o=1
REQ-008 next_pc_o SHALL be taken ? (pc + imm) : (pc + 4), computed modulo 2^XLEN with carry-out discarded.
REQ-009 mispredict_o SHALL be valid_o & !illegal_o & (taken_o != pred_taken); for an illegal entry it SHALL be 0.
REQ-010 A request SHALL be accepted on a rising edge where valid_i & ready_o; its result SHALL appear on valid_o exactly STAGES cycles later when no stall occurs.
REQ-011 With STAGES=1, a single register SHALL hold the full result. With STAGES=2:
- stage 1 registers eq/lt/ltu, funct3, pc, imm and pred;
- stage 2 registers taken, next_pc and mispredict.
REQ-012 Each stage SHALL advance when it is empty or the stage after it advances.
REQ-013 ready_o SHALL equal !valid of the last stage | ready_i, cascaded per stage; there is no skid buffer.
REQ-014 While valid_o & !ready_i, all result outputs SHALL be held stable.
REQ-015 Back-to-back requests with ready_i held high SHALL sustain one result per cycle.
REQ-016 flush_i SHALL clear all stage valid bits on the next edge, take priority over a simultaneous accept (the accepted request is dropped), and leave counters unchanged.
REQ-017 Counter update on each edge where valid_o & ready_i & !flush_i:
- br_cnt_o SHALL increment by 1.
- mp_cnt_o SHALL increment by 1 if mispredict_o.
- Both SHALL wrap from 2^CNTW-1 to 0.
REQ-018 When valid_o = 0, taken_o, mispredict_o, illegal_o, BrEq_o and BrLt_o SHALL be 0.

Reset
REQ-019 Assertion of rst_ni SHALL immediately clear all valid bits, outputs and counters to 0, independent of the clock.
REQ-020 Reset asserted mid-operation SHALL discard in-flight entries with no result emitted.
REQ-021 After reset deassertion, ready_o SHALL be 1.

Structure
REQ-022 Package branch_pkg SHALL hold:
- enum br_funct3_e (BEQ, BNE, BLT, BGE, BLTU, BGEU);
- constant PC_INC = 4.
REQ-023 Sub-module branch_cmp_core (combinational, parameter XLEN) SHALL produce eq/lt/ltu and be instantiated once.
REQ-024 All registers SHALL reside in branch_resolve_unit.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- BLT, rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred=0 -> taken=1, next_pc=0x120, mispredict=1, mp_cnt=1.
- BLTU with the same operands and pred=0 -> taken=0, next_pc=0x104, mispredict=0.
- funct3=010 -> illegal_o=1, taken=0, next_pc=pc+4.
- pc=0xFFFFFFFC, BEQ, equal operands, imm=8 -> next_pc=0x4.
- STAGES=2, ready_i=0 for 3 cycles with 3 requests -> outputs stable, ready_o=0, then 3 results in order.
- flush_i in the same cycle as an accept, with 2 entries in flight -> valid_o=0 next cycle, counters unchanged.
- Reset asserted mid-stream -> valid_o=0 and counters=0 immediately.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch types and constants for the branch resolve unit.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/branch_cmp_core.sv
// Raw operand comparator: equality, signed and unsigned less-than.
module branch_cmp_core #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);

  assign eq  = (rs1 == rs2);
  assign lt  = ($signed(rs1) < $signed(rs2));
  assign ltu = (rs1 < rs2);

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution pipeline: compare, decode, next-PC, mispredict, counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int CNTW   = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            pred_taken_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            taken_o,
  output logic [XLEN-1:0] next_pc_o,
  output logic            mispredict_o,
  output logic            illegal_o,
  output logic            BrEq_o,
  output logic            BrLt_o,
  output logic [CNTW-1:0] br_cnt_o,
  output logic [CNTW-1:0] mp_cnt_o
);

  logic eq_c, lt_c, ltu_c;

  branch_cmp_core #(
    .XLEN(XLEN)
  ) u_cmp (
    .rs1(rs1_i),
    .rs2(rs2_i),
    .eq (eq_c),
    .lt (lt_c),
    .ltu(ltu_c)
  );

  // Resolve inputs: straight from the ports or from stage 1.
  logic            r_vld;
  logic            r_eq, r_lt, r_ltu, r_pred;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_pc, r_imm;

  logic            r_taken, r_ill, r_brlt, r_mp;
  logic [XLEN-1:0] r_npc;

  logic            o_v, o_taken, o_mp, o_ill;
  logic            o_eq, o_brlt;
  logic [XLEN-1:0] o_npc;
  logic [CNTW-1:0] br_q, mp_q;

  logic last_adv, fire;

  assign last_adv = !o_v | ready_i;
  assign fire     = o_v & ready_i & !flush_i;

  always_comb begin
    r_taken = 1'b0;
    r_ill   = 1'b0;
    case (r_f3)
      BEQ:     r_taken = r_eq;
      BNE:     r_taken = !r_eq;
      BLT:     r_taken = r_lt;
      BGE:     r_taken = !r_lt;
      BLTU:    r_taken = r_ltu;
      BGEU:    r_taken = !r_ltu;
      default: r_ill   = 1'b1;
    endcase
    r_brlt = (r_f3 == BLT || r_f3 == BGE)
           ? r_lt : r_ltu;
    r_npc  = r_taken ? (r_pc + r_imm)
           : (r_pc + XLEN'(PC_INC));
    r_mp   = !r_ill & (r_taken != r_pred);
  end

  if (STAGES == 1) begin : g_one
    assign ready_o = last_adv;
    assign r_vld   = valid_i;
    assign r_eq    = eq_c;
    assign r_lt    = lt_c;
    assign r_ltu   = ltu_c;
    assign r_pred  = pred_taken_i;
    assign r_f3    = funct3_i;
    assign r_pc    = pc_i;
    assign r_imm   = imm_i;
  end else begin : g_two
    logic            s_v, s_adv;
    logic            s_eq, s_lt, s_ltu, s_pred;
    logic [2:0]      s_f3;
    logic [XLEN-1:0] s_pc, s_imm;

    assign s_adv   = !s_v | last_adv;
    assign ready_o = s_adv;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s_v    <= 1'b0;
        s_eq   <= 1'b0;
        s_lt   <= 1'b0;
        s_ltu  <= 1'b0;
        s_pred <= 1'b0;
        s_f3   <= '0;
        s_pc   <= '0;
        s_imm  <= '0;
      end else begin
        if (flush_i) s_v <= 1'b0;
        else if (s_adv) s_v <= valid_i;
        if (s_adv && valid_i) begin
          s_eq   <= eq_c;
          s_lt   <= lt_c;
          s_ltu  <= ltu_c;
          s_pred <= pred_taken_i;
          s_f3   <= funct3_i;
          s_pc   <= pc_i;
          s_imm  <= imm_i;
        end
      end
    end

    assign r_vld  = s_v;
    assign r_eq   = s_eq;
    assign r_lt   = s_lt;
    assign r_ltu  = s_ltu;
    assign r_pred = s_pred;
    assign r_f3   = s_f3;
    assign r_pc   = s_pc;
    assign r_imm  = s_imm;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      o_v     <= 1'b0;
      o_taken <= 1'b0;
      o_mp    <= 1'b0;
      o_ill   <= 1'b0;
      o_eq    <= 1'b0;
      o_brlt  <= 1'b0;
      o_npc   <= '0;
      br_q    <= '0;
      mp_q    <= '0;
    end else begin
      if (flush_i) o_v <= 1'b0;
      else if (last_adv) o_v <= r_vld;
      if (last_adv && r_vld) begin
        o_taken <= r_taken;
        o_mp    <= r_mp;
        o_ill   <= r_ill;
        o_eq    <= r_eq;
        o_brlt  <= r_brlt;
        o_npc   <= r_npc;
      end
      if (fire) begin
        br_q <= br_q + CNTW'(1);
        if (o_mp) mp_q <= mp_q + CNTW'(1);
      end
    end
  end

  // Flags are forced low whenever no result is presented.
  assign valid_o      = o_v;
  assign taken_o      = o_v & o_taken;
  assign mispredict_o = o_v & o_mp;
  assign illegal_o    = o_v & o_ill;
  assign BrEq_o       = o_v & o_eq;
  assign BrLt_o       = o_v & o_brlt;
  assign next_pc_o    = o_npc;
  assign br_cnt_o     = br_q;
  assign mp_cnt_o     = mp_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: STAGES=1 and STAGES=2 instances
// driven together, checked against a reference model scoreboard.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int CNTW = 4;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] npc;
    logic            mp;
    logic            ill;
    logic            eq;
    logic            brlt;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [1:0]      vin;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1, rs2, pc, imm;
  logic            pred, flush, ready;

  logic [1:0]      rdy, vo, tk, mpo, ilo, eqo, lto;
  logic [XLEN-1:0] npc [2];
  logic [CNTW-1:0] brc [2];
  logic [CNTW-1:0] mpc [2];

  exp_t            q   [2][$];
  logic [CNTW-1:0] mbr [2] = '{default: '0};
  logic [CNTW-1:0] mmp [2] = '{default: '0};

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  branch_resolve_unit #(
    .XLEN(XLEN), .STAGES(1), .CNTW(CNTW)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni),
    .valid_i(vin[0]), .ready_o(rdy[0]),
    .funct3_i(funct3), .rs1_i(rs1), .rs2_i(rs2),
    .pc_i(pc), .imm_i(imm), .pred_taken_i(pred),
    .flush_i(flush), .valid_o(vo[0]), .ready_i(ready),
    .taken_o(tk[0]), .next_pc_o(npc[0]),
    .mispredict_o(mpo[0]), .illegal_o(ilo[0]),
    .BrEq_o(eqo[0]), .BrLt_o(lto[0]),
    .br_cnt_o(brc[0]), .mp_cnt_o(mpc[0])
  );

  branch_resolve_unit #(
    .XLEN(XLEN), .STAGES(2), .CNTW(CNTW)
  ) u_dut2 (
    .clk_i(clk), .rst_ni(rst_ni),
    .valid_i(vin[1]), .ready_o(rdy[1]),
    .funct3_i(funct3), .rs1_i(rs1), .rs2_i(rs2),
    .pc_i(pc), .imm_i(imm), .pred_taken_i(pred),
    .flush_i(flush), .valid_o(vo[1]), .ready_i(ready),
    .taken_o(tk[1]), .next_pc_o(npc[1]),
    .mispredict_o(mpo[1]), .illegal_o(ilo[1]),
    .BrEq_o(eqo[1]), .BrLt_o(lto[1]),
    .br_cnt_o(brc[1]), .mp_cnt_o(mpc[1])
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f3,
                                 input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b,
                                 input logic [XLEN-1:0] p,
                                 input logic [XLEN-1:0] off,
                                 input logic pr);
    exp_t e;
    logic slt, ult;
    e     = '0;
    e.eq  = (a == b);
    slt   = ($signed(a) < $signed(b));
    ult   = (a < b);
    case (f3)
      3'd0:    e.taken = e.eq;
      3'd1:    e.taken = !e.eq;
      3'd4:    e.taken = slt;
      3'd5:    e.taken = !slt;
      3'd6:    e.taken = ult;
      3'd7:    e.taken = !ult;
      default: e.ill   = 1'b1;
    endcase
    e.brlt = (f3 == 3'd4 || f3 == 3'd5) ? slt : ult;
    e.npc  = e.taken ? p + off : p + 32'd4;
    e.mp   = !e.ill && (e.taken != pr);
    return e;
  endfunction

  // Scoreboard: the head entry must be on the outputs whenever valid_o is high.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rst_ni) begin
        q[d].delete();
        mbr[d] = '0;
        mmp[d] = '0;
      end
      chk($sformatf("br_cnt%0d", d), 64'(brc[d]), 64'(mbr[d]));
      chk($sformatf("mp_cnt%0d", d), 64'(mpc[d]), 64'(mmp[d]));
      if (vo[d]) begin
        if (q[d].size() == 0) begin
          chk($sformatf("unexpected%0d", d), 64'd1, 64'd0);
        end else begin
          e = q[d][0];
          chk($sformatf("taken%0d", d), 64'(tk[d]), 64'(e.taken));
          chk($sformatf("next_pc%0d", d), 64'(npc[d]), 64'(e.npc));
          chk($sformatf("mispred%0d", d), 64'(mpo[d]), 64'(e.mp));
          chk($sformatf("illegal%0d", d), 64'(ilo[d]), 64'(e.ill));
          chk($sformatf("br_eq%0d", d), 64'(eqo[d]), 64'(e.eq));
          chk($sformatf("br_lt%0d", d), 64'(lto[d]), 64'(e.brlt));
          if (ready && !flush) begin
            void'(q[d].pop_front());
            mbr[d] = mbr[d] + 1'b1;
            if (e.mp) mmp[d] = mmp[d] + 1'b1;
          end
        end
      end else begin
        chk($sformatf("idle_flags%0d", d),
            64'({tk[d], mpo[d], ilo[d], eqo[d], lto[d]}), 64'd0);
      end
      if (flush) q[d].delete();
      else if (vin[d] && rdy[d] && rst_ni)
        q[d].push_back(model(funct3, rs1, rs2, pc, imm, pred));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f3,
                      input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b,
                      input logic [XLEN-1:0] p,
                      input logic [XLEN-1:0] off,
                      input logic pr);
    logic acc0, acc1;
    funct3 = f3;
    rs1    = a;
    rs2    = b;
    pc     = p;
    imm    = off;
    pred   = pr;
    vin    = 2'b11;
    for (int n = 0; n < 20 && vin != 2'b00; n++) begin
      @(negedge clk);
      acc0 = vin[0] & rdy[0];
      acc1 = vin[1] & rdy[1];
      @(posedge clk);
      #1;
      if (acc0) vin[0] = 1'b0;
      if (acc1) vin[1] = 1'b0;
    end
    if (vin != 2'b00) begin
      chk("send_timeout", 64'(vin), 64'd0);
      vin = 2'b00;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (q[0].size() != 0 || q[1].size() != 0); n++)
      step();
    chk("drain0", 64'(q[0].size()), 64'd0);
    chk("drain1", 64'(q[1].size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] a, b;
    int c0;
    rst_ni = 1'b1;
    vin    = 2'b00;
    funct3 = '0;
    rs1    = '0;
    rs2    = '0;
    pc     = '0;
    imm    = '0;
    pred   = 1'b0;
    flush  = 1'b0;
    ready  = 1'b0;

    #1 rst_ni = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_valid%0d", d), 64'(vo[d]), 64'd0);
      chk($sformatf("rst_br%0d", d), 64'(brc[d]), 64'd0);
      chk($sformatf("rst_mp%0d", d), 64'(mpc[d]), 64'd0);
      chk($sformatf("rst_ready%0d", d), 64'(rdy[d]), 64'd1);
    end
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    ready = 1'b1;

    // BLT signed: -1 < 1, predicted not-taken
    send(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
    chk("lat_valid1", 64'(vo[0]), 64'd1);
    chk("lat_valid2", 64'(vo[1]), 64'd0);
    step();
    chk("lat2_valid1", 64'(vo[0]), 64'd0);
    chk("lat2_valid2", 64'(vo[1]), 64'd1);
    chk("blt_mpcnt1", 64'(mpc[0]), 64'd1);
    step();
    chk("blt_mpcnt2", 64'(mpc[1]), 64'd1);

    send(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
    send(3'b010, 32'h7, 32'h7, 32'h200, 32'h40, 1'b1);
    send(3'b000, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h8, 1'b1);

    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? a : $urandom;
      send(3'($urandom_range(0, 7)), a, b, $urandom, $urandom,
           1'($urandom_range(0, 1)));
    end
    chk("throughput", 64'(cyc - c0), 64'd8);
    drain();

    // Downstream stall with three requests
    ready = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("stall_ready1", 64'(rdy[0]), 64'd0);
        chk("stall_ready2", 64'(rdy[1]), 64'd0);
        chk("stall_valid1", 64'(vo[0]), 64'd1);
        chk("stall_valid2", 64'(vo[1]), 64'd1);
        @(posedge clk);
        #2 ready = 1'b1;
      end
    join_none
    send(3'b101, 32'h3, 32'h9, 32'h400, 32'h10, 1'b1);
    send(3'b001, 32'h1, 32'h2, 32'h500, 32'hFFFF_FFF0, 1'b0);
    send(3'b111, 32'h8000_0000, 32'h1, 32'h600, 32'h4, 1'b0);
    drain();

    // Flush together with an accept, two entries in flight
    ready = 1'b1;
    send(3'b000, 32'h11, 32'h11, 32'h700, 32'h8, 1'b0);
    send(3'b100, 32'h1, 32'h2, 32'h800, 32'h8, 1'b0);
    funct3 = 3'b000;
    rs1    = 32'h0;
    rs2    = 32'h0;
    vin    = 2'b11;
    flush  = 1'b1;
    step();
    vin   = 2'b00;
    flush = 1'b0;
    chk("flush_valid1", 64'(vo[0]), 64'd0);
    chk("flush_valid2", 64'(vo[1]), 64'd0);
    drain();

    // Reset in the middle of a stream
    send(3'b001, 32'h1, 32'h3, 32'h900, 32'h20, 1'b1);
    send(3'b110, 32'h1, 32'h3, 32'hA00, 32'h20, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("mid_rst_valid%0d", d), 64'(vo[d]), 64'd0);
      chk($sformatf("mid_rst_br%0d", d), 64'(brc[d]), 64'd0);
      chk($sformatf("mid_rst_mp%0d", d), 64'(mpc[d]), 64'd0);
    end
    step();
    rst_ni = 1'b1;
    ready  = 1'b0;
    #1;
    chk("post_rst_ready1", 64'(rdy[0]), 64'd1);
    chk("post_rst_ready2", 64'(rdy[1]), 64'd1);
    ready = 1'b1;
    send(3'b101, 32'h9, 32'h3, 32'hB00, 32'h40, 1'b1);
    drain();
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
